// File: rtl/ysyx_22050058_lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states and
// the natural-alignment rule.
package ysyx_22050058_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10,
        LSU_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_DONE
    } lsu_state_e;

    function automatic logic size_misaligned(lsu_size_e size, logic [2:0] off);
        case (size)
            LSU_B:   return 1'b0;
            LSU_H:   return off[0];
            LSU_W:   return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050058_lsu_align.sv
// Combinational lane alignment: byte strobes, store-data shift, load-data
// extraction with sign/zero extension, and the misalignment flag.
module ysyx_22050058_lsu_align
    import ysyx_22050058_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic [1:0]          size,
    input  logic                zext,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata_raw,
    output logic [DATA_W/8-1:0] strobe,
    output logic [DATA_W-1:0]   wdata_sh,
    output logic [DATA_W-1:0]   rdata_fmt,
    output logic [ADDR_W-1:0]   addr_al,
    output logic                misalign
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    lsu_size_e        size_e;
    logic [OFF_W-1:0] off;
    logic [BYTES-1:0] size_mask;
    logic [DATA_W-1:0] rd_shifted;

    assign size_e     = lsu_size_e'(size);
    assign off        = addr[OFF_W-1:0];
    assign strobe     = size_mask << off;
    assign wdata_sh   = wdata << {off, 3'b000};
    assign rd_shifted = rdata_raw >> {off, 3'b000};
    assign addr_al    = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign misalign   = size_misaligned(size_e, addr[2:0]);

    always_comb begin
        case (size_e)
            LSU_B:   size_mask = BYTES'(8'h01);
            LSU_H:   size_mask = BYTES'(8'h03);
            LSU_W:   size_mask = BYTES'(8'h0F);
            default: size_mask = BYTES'(8'hFF);
        endcase
    end

    always_comb begin
        case (size_e)
            LSU_B:   rdata_fmt = zext ? DATA_W'(rd_shifted[7:0])
                                      : {{(DATA_W-8){rd_shifted[7]}}, rd_shifted[7:0]};
            LSU_H:   rdata_fmt = zext ? DATA_W'(rd_shifted[15:0])
                                      : {{(DATA_W-16){rd_shifted[15]}}, rd_shifted[15:0]};
            LSU_W:   rdata_fmt = zext ? DATA_W'(rd_shifted[31:0])
                                      : {{(DATA_W-32){rd_shifted[31]}}, rd_shifted[31:0]};
            default: rdata_fmt = rd_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22050058_lsu.sv
// Load/store unit: one outstanding data-memory transaction at a time, with
// pipeline stall request, flush kill, misalignment trap and watchdog.
module ysyx_22050058_lsu
    import ysyx_22050058_lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int          TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [1:0]          lsu_size_i,
    input  logic                lsu_unsigned_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_done_o,
    output logic                lsu_stallreq_o,
    output logic                lsu_misalign_o,
    output logic                lsu_err_o,
    output logic                memre_o,
    output logic [DATA_W/8-1:0] memwe_o,
    output logic [ADDR_W-1:0]   memaddr_o,
    output logic [DATA_W-1:0]   memwdata_o,
    input  logic [DATA_W-1:0]   memrdata_i,
    input  logic                memrdatavaild_i,
    input  logic                memwdatavaild_i
);
    localparam int unsigned TMR_W = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);

    lsu_state_e         state;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         size_q;
    logic               zext_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               kill_q;
    logic [TMR_W-1:0]   timer;

    logic               in_idle;
    logic               bus_valid;
    logic               timeout_hit;
    logic [DATA_W/8-1:0] al_strobe;
    logic [DATA_W-1:0]  al_wdata;
    logic [DATA_W-1:0]  al_rdata;
    logic [ADDR_W-1:0]  al_addr;
    logic               al_misalign;

    // Idle: align the incoming request; waiting: re-derive from the captured one.
    assign in_idle = (state == S_IDLE);

    ysyx_22050058_lsu_align #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_align (
        .size      (in_idle ? lsu_size_i     : size_q),
        .zext      (in_idle ? lsu_unsigned_i : zext_q),
        .addr      (in_idle ? lsu_addr_i     : addr_q),
        .wdata     (in_idle ? lsu_wdata_i    : wdata_q),
        .rdata_raw (memrdata_i),
        .strobe    (al_strobe),
        .wdata_sh  (al_wdata),
        .rdata_fmt (al_rdata),
        .addr_al   (al_addr),
        .misalign  (al_misalign)
    );

    assign bus_valid   = (state == S_RD_WAIT) ? memrdatavaild_i : memwdatavaild_i;
    assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));

    assign lsu_stallreq_o = (in_idle && lsu_req_i && !flush_i && !al_misalign)
                          || (state == S_RD_WAIT) || (state == S_WR_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            size_q         <= '0;
            zext_q         <= 1'b0;
            wdata_q        <= '0;
            kill_q         <= 1'b0;
            timer          <= '0;
            lsu_rdata_o    <= '0;
            lsu_done_o     <= 1'b0;
            lsu_misalign_o <= 1'b0;
            lsu_err_o      <= 1'b0;
            memre_o        <= 1'b0;
            memwe_o        <= '0;
            memaddr_o      <= '0;
            memwdata_o     <= '0;
        end else begin
            lsu_done_o     <= 1'b0;
            lsu_misalign_o <= 1'b0;
            lsu_err_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer  <= '0;
                    kill_q <= 1'b0;
                    if (lsu_req_i && !flush_i) begin
                        addr_q  <= lsu_addr_i;
                        size_q  <= lsu_size_i;
                        zext_q  <= lsu_unsigned_i;
                        wdata_q <= lsu_wdata_i;
                        if (al_misalign) begin
                            lsu_misalign_o <= 1'b1;
                            lsu_done_o     <= 1'b1;
                        end else begin
                            memaddr_o <= al_addr;
                            if (lsu_we_i) begin
                                memwe_o    <= al_strobe;
                                memwdata_o <= al_wdata;
                                state      <= S_WR_WAIT;
                            end else begin
                                memre_o    <= 1'b1;
                                memwe_o    <= '0;
                                memwdata_o <= '0;
                                state      <= S_RD_WAIT;
                            end
                        end
                    end
                end
                S_RD_WAIT, S_WR_WAIT: begin
                    if (bus_valid || timeout_hit) begin
                        memre_o    <= 1'b0;
                        memwe_o    <= '0;
                        memaddr_o  <= '0;
                        memwdata_o <= '0;
                        timer      <= '0;
                        state      <= S_IDLE;
                        if (!bus_valid) begin
                            lsu_err_o <= 1'b1;
                        end else if (!(kill_q || flush_i)) begin
                            lsu_done_o  <= 1'b1;
                            lsu_rdata_o <= (state == S_RD_WAIT) ? al_rdata : '0;
                            state       <= S_DONE;
                        end
                    end else begin
                        if (timer != '1) begin
                            timer <= timer + 1'b1;
                        end
                        if (flush_i) begin
                            kill_q <= 1'b1;
                        end
                        memaddr_o <= al_addr;
                        if (state == S_WR_WAIT) begin
                            memwe_o    <= al_strobe;
                            memwdata_o <= al_wdata;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050058_lsu.sv
// Self-checking bench for ysyx_22050058_lsu: directed corner cases followed by
// randomized transactions against a byte-level reference model.
module tb_ysyx_22050058_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [63:0] lsu_addr_i;
    logic [63:0] lsu_wdata_i;
    logic [63:0] lsu_rdata_o;
    logic        lsu_done_o;
    logic        lsu_stallreq_o;
    logic        lsu_misalign_o;
    logic        lsu_err_o;
    logic        memre_o;
    logic [7:0]  memwe_o;
    logic [63:0] memaddr_o;
    logic [63:0] memwdata_o;
    logic [63:0] memrdata_i;
    logic        memrdatavaild_i;
    logic        memwdatavaild_i;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [63:0] last_rdata = '0;

    always #5 clk = ~clk;

    ysyx_22050058_lsu #(
        .DATA_W  (64),
        .ADDR_W  (64),
        .TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_unsigned_i  (lsu_unsigned_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_wdata_i     (lsu_wdata_i),
        .lsu_rdata_o     (lsu_rdata_o),
        .lsu_done_o      (lsu_done_o),
        .lsu_stallreq_o  (lsu_stallreq_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .lsu_err_o       (lsu_err_o),
        .memre_o         (memre_o),
        .memwe_o         (memwe_o),
        .memaddr_o       (memaddr_o),
        .memwdata_o      (memwdata_o),
        .memrdata_i      (memrdata_i),
        .memrdatavaild_i (memrdatavaild_i),
        .memwdatavaild_i (memwdatavaild_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned nbytes(logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic ref_misaligned(logic [1:0] size, logic [63:0] addr);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [7:0] ref_strobe(logic [1:0] size, logic [63:0] addr);
        logic [7:0] s = '0;
        for (int unsigned i = 0; i < nbytes(size); i++) s[addr[2:0] + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_load(logic [1:0] size, logic uns,
                                             logic [63:0] addr, logic [63:0] mem);
        int unsigned n   = nbytes(size);
        int unsigned off = addr[2:0];
        logic [63:0] v   = '0;
        for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = mem[8*(off+i) +: 8];
        if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    // flush_at = 0 means no flush; early_valid raises valid in the request cycle.
    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] mem, input int unsigned lat,
                       input int unsigned flush_at, input logic early_valid);
        logic        mis = ref_misaligned(size, addr);
        logic [63:0] exp_wd = we ? (wdata << (8 * addr[2:0])) : 64'd0;
        logic [7:0]  exp_we = we ? ref_strobe(size, addr) : 8'd0;
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = uns;
        lsu_addr_i = addr; lsu_wdata_i = wdata; memrdata_i = mem;
        memrdatavaild_i = early_valid & !we; memwdatavaild_i = early_valid & we;
        #1;
        chk("stall_req", {63'd0, lsu_stallreq_o}, {63'd0, !mis});
        step();
        lsu_req_i = 1'b0; memrdatavaild_i = 1'b0; memwdatavaild_i = 1'b0;
        if (mis) begin
            chk("misalign_pulse", {63'd0, lsu_misalign_o}, 64'd1);
            chk("misalign_done", {63'd0, lsu_done_o}, 64'd1);
            chk("misalign_bus", {55'd0, memre_o, memwe_o}, 64'd0);
            step();
            chk("misalign_clear", {62'd0, lsu_misalign_o, lsu_done_o}, 64'd0);
            return;
        end
        for (int unsigned c = 1; c <= lat; c++) begin
            chk("wait_re", {63'd0, memre_o}, {63'd0, !we});
            chk("wait_we", {56'd0, memwe_o}, {56'd0, exp_we});
            chk("wait_addr", memaddr_o, addr & ~64'd7);
            chk("wait_wdata", memwdata_o, exp_wd);
            chk("wait_stall_done", {62'd0, lsu_stallreq_o, lsu_done_o}, 64'd2);
            flush_i = (c == flush_at);
            if (c == lat) begin
                memrdatavaild_i = !we;
                memwdatavaild_i = we;
            end
            step();
            flush_i = 1'b0; memrdatavaild_i = 1'b0; memwdatavaild_i = 1'b0;
        end
        if (flush_at != 0 && flush_at <= lat) begin
            chk("kill_no_done", {63'd0, lsu_done_o}, 64'd0);
            chk("kill_rdata", lsu_rdata_o, last_rdata);
        end else begin
            last_rdata = we ? 64'd0 : ref_load(size, uns, addr, mem);
            chk("done_pulse", {63'd0, lsu_done_o}, 64'd1);
            chk("done_rdata", lsu_rdata_o, last_rdata);
        end
        chk("end_bus", {55'd0, memre_o, memwe_o}, 64'd0);
        chk("end_stall", {63'd0, lsu_stallreq_o}, 64'd0);
        step();
        chk("done_clear", {63'd0, lsu_done_o}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0;
        lsu_size_i = 2'b00; lsu_unsigned_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
        memrdata_i = '0; memrdatavaild_i = 1'b0; memwdatavaild_i = 1'b0;
        step(); step();
        chk("rst_rdata", lsu_rdata_o, 64'd0);
        chk("rst_flags", {60'd0, lsu_done_o, lsu_stallreq_o, lsu_misalign_o, lsu_err_o}, 64'd0);
        chk("rst_bus", {55'd0, memre_o, memwe_o}, 64'd0);
        chk("rst_addr", memaddr_o, 64'd0);
        chk("rst_wdata", memwdata_o, 64'd0);
        rst = 1'b0;
        step();

        // LB/LBU sign extension; early valid in the request cycle must be ignored.
        txn(1'b0, 2'b00, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 2, 0, 1'b1);
        chk("lb_value", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        txn(1'b0, 2'b00, 1'b1, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 2, 0, 1'b0);
        chk("lbu_value", last_rdata, 64'h0000_0000_0000_0080);
        txn(1'b1, 2'b01, 1'b0, 64'h8000_0006, 64'h1234, 64'd0, 2, 0, 1'b0);
        chk("sh_strobe_ref", {56'd0, ref_strobe(2'b01, 64'h8000_0006)}, 64'h00C0);
        txn(1'b0, 2'b10, 1'b0, 64'h8000_0002, 64'd0, 64'd0, 1, 0, 1'b0);
        txn(1'b0, 2'b11, 1'b0, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 4, 2, 1'b0);

        // Flush alongside an idle request: nothing accepted.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b11; lsu_addr_i = 64'h8000_0010;
        flush_i = 1'b1;
        #1;
        chk("flush_idle_stall", {63'd0, lsu_stallreq_o}, 64'd0);
        step();
        lsu_req_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_bus", {55'd0, memre_o, memwe_o}, 64'd0);

        // Watchdog: SD never acknowledged.
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 2'b11; lsu_unsigned_i = 1'b0;
        lsu_addr_i = 64'h8000_0020; lsu_wdata_i = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        lsu_req_i = 1'b0;
        for (int unsigned c = 1; c <= 4; c++) begin
            chk("wd_we_held", {56'd0, memwe_o}, 64'hFF);
            chk("wd_no_err", {63'd0, lsu_err_o}, 64'd0);
            step();
        end
        chk("wd_err", {63'd0, lsu_err_o}, 64'd1);
        chk("wd_we_drop", {56'd0, memwe_o}, 64'd0);
        chk("wd_no_done", {62'd0, lsu_done_o, lsu_stallreq_o}, 64'd0);
        step();
        chk("wd_err_clear", {63'd0, lsu_err_o}, 64'd0);

        // Reset mid-transaction; a late valid must not complete anything.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 64'h8000_0004;
        step();
        lsu_req_i = 1'b0;
        chk("midrst_re", {63'd0, memre_o}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_bus", {55'd0, memre_o, memwe_o}, 64'd0);
        chk("midrst_stall", {63'd0, lsu_stallreq_o}, 64'd0);
        memrdatavaild_i = 1'b1; memrdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        memrdatavaild_i = 1'b0;
        chk("late_valid_done", {63'd0, lsu_done_o}, 64'd0);
        chk("late_valid_rdata", lsu_rdata_o, 64'd0);
        last_rdata = '0;

        for (int unsigned n = 0; n < 40; n++) begin
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            logic        we  = 1'($urandom_range(0, 1));
            logic        un  = 1'($urandom_range(0, 1));
            logic [63:0] ad  = 64'h8000_0000 + 64'($urandom_range(0, 63));
            logic [63:0] wd  = {$urandom, $urandom};
            logic [63:0] md  = {$urandom, $urandom};
            int unsigned lat = $urandom_range(1, 3);
            int unsigned fl  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0;
            txn(we, sz, un, ad, wd, md, lat, fl, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
